// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the uDLX data-side memory bridge.
// Holds the bridge FSM encoding and the bus_we direction values.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RDONE = 2'd3
    } bridge_state_t;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

endpackage

// File: rtl/dlx_wbuf_fifo.sv
// Posted-write buffer: synchronous FIFO with power-of-two depth.
// Full/empty come from the registered count, so a full buffer refuses a push even when popping.
module dlx_wbuf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/dlx_data_mem_bridge.sv
// uDLX MEM-stage data port to variable-latency req/ack bus bridge.
// Stores are posted into a write buffer; loads drain the buffer, then stall the core until data returns.
module dlx_data_mem_bridge
    import dlx_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int WBUF_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          core_rd_en,
    input  logic                          core_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0]    core_addr,
    input  logic [DATA_WIDTH-1:0]         core_wdata,
    output logic [DATA_WIDTH-1:0]         core_rdata,
    output logic                          core_hold,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [DATA_ADDR_WIDTH-1:0]    bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wdata,
    input  logic                          bus_ack,
    input  logic [DATA_WIDTH-1:0]         bus_rdata,
    output bridge_state_t                 dbg_state
);

    localparam int EW = DATA_ADDR_WIDTH + DATA_WIDTH;

    bridge_state_t                state_q, state_d;
    logic                         bus_req_q, bus_req_d;
    logic                         bus_we_q, bus_we_d;
    logic [DATA_ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]        bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0]        core_rdata_q, core_rdata_d;
    logic                         rd_done_q, rd_done_d;

    logic                         fifo_push;
    logic                         fifo_pop;
    logic [EW-1:0]                fifo_head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         ack_valid;

    // Bus handshake: bus_req and its payload stay stable until a rising edge
    // where bus_req & bus_ack; that edge completes the beat and drops bus_req.
    assign ack_valid = bus_req_q & bus_ack;
    assign fifo_push = core_wr_en & ~core_rd_en;
    assign fifo_pop  = (state_q == ST_WRITE) & ack_valid;

    dlx_wbuf_fifo #(
        .WIDTH (EW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({core_addr, core_wdata}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (wbuf_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= BUS_RD;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            core_rdata_q <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            core_rdata_q <= core_rdata_d;
            rd_done_q    <= rd_done_d;
        end
    end

    // Buffered writes win over a pending load, which keeps RAW order without forwarding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WRITE;
                end else if (core_rd_en && !rd_done_q) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: if (ack_valid) state_d = ST_IDLE;
            ST_READ:  if (ack_valid) state_d = ST_RDONE;
            ST_RDONE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        core_rdata_d = core_rdata_q;
        rd_done_d    = rd_done_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_WRITE) begin
                    bus_req_d                 = 1'b1;
                    bus_we_d                  = BUS_WR;
                    {bus_addr_d, bus_wdata_d} = fifo_head;
                end else if (state_d == ST_READ) begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = BUS_RD;
                    bus_addr_d = core_addr;
                end
            end
            ST_WRITE: begin
                if (ack_valid) bus_req_d = 1'b0;
            end
            ST_READ: begin
                if (ack_valid) begin
                    bus_req_d    = 1'b0;
                    core_rdata_d = bus_rdata;
                    rd_done_d    = 1'b1;
                end
            end
            ST_RDONE: rd_done_d = 1'b0;
            default: ;
        endcase
    end

    // Hold is combinational so the core stalls in the same cycle it presents the access.
    always_comb begin
        core_hold = 1'b0;
        if (!rst) begin
            core_hold = (core_rd_en & ~rd_done_q) | (core_wr_en & ~core_rd_en & fifo_full);
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign core_rdata = core_rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dlx_data_mem_bridge.sv
// Directed bench for dlx_data_mem_bridge: wait-state slave with memory model,
// expected-transaction queue, and inline immediate assertions.
module tb_dlx_data_mem_bridge;
    import dlx_mem_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_rd_en = 1'b0;
    logic          core_wr_en = 1'b0;
    logic [31:0]   core_addr = '0;
    logic [31:0]   core_wdata = '0;
    logic [31:0]   core_rdata;
    logic          core_hold;
    logic [2:0]    wbuf_count;
    logic          bus_req;
    logic          bus_we;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_ack;
    logic [31:0]   bus_rdata = '0;
    bridge_state_t dbg_state;

    logic          slave_ack = 1'b0;
    logic          spur_ack = 1'b0;
    int            wait_states = 0;
    int            wait_cnt = 0;
    logic [31:0]   mem_model [logic [31:0]];
    logic [64:0]   exp_q [$];
    logic [64:0]   slave_txn;
    int            n_vec = 0;
    int            n_err = 0;
    int            illegal_cycles = 0;
    bit            illegal_noted = 1'b0;

    assign bus_ack = slave_ack | spur_ack;

    dlx_data_mem_bridge #(
        .DATA_WIDTH      (32),
        .DATA_ADDR_WIDTH (32),
        .WBUF_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_rd_en (core_rd_en),
        .core_wr_en (core_wr_en),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_hold  (core_hold),
        .wbuf_count (wbuf_count),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: acks after wait_states cycles of bus_req, keeps a memory model, scores each beat.
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            if (wait_cnt >= wait_states) begin
                slave_ack = 1'b1;
                if (bus_we == BUS_WR) begin
                    mem_model[bus_addr] = bus_wdata;
                    slave_txn = {1'b1, bus_addr, bus_wdata};
                end else begin
                    bus_rdata = mem_model.exists(bus_addr) ? mem_model[bus_addr] : 32'hDEAD_0000;
                    slave_txn = {1'b0, bus_addr, bus_rdata};
                end
                n_vec++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL bus_unexpected: observed txn %0h expected none", slave_txn);
                end
                if (exp_q.size() > 0) check("bus_txn", 96'(slave_txn), 96'(exp_q.pop_front()));
                wait_cnt = 0;
            end else begin
                slave_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            slave_ack = 1'b0;
            wait_cnt  = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && core_rd_en && core_wr_en) begin
            illegal_cycles++;
            if (!illegal_noted) begin
                $display("note: illegal simultaneous rd_en/wr_en request seen at %0t", $time);
                illegal_noted = 1'b1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a store; returns cycles held and the count seen on its first cycle.
    task automatic store_hold(input logic [31:0] a, input logic [31:0] d,
                              output int holds, output logic [2:0] first_count);
        bit done;
        done  = 1'b0;
        holds = 0;
        next_cycle();
        core_rd_en = 1'b0;
        core_wr_en = 1'b1;
        core_addr  = a;
        core_wdata = d;
        @(negedge clk);
        first_count = wbuf_count;
        for (int i = 0; i < 200 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (!core_hold) done = 1'b1;
            else begin
                holds++;
                next_cycle();
            end
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL store_timeout: observed hold stuck, expected release");
        end
    endtask

    // Presents a load (optionally with wr_en too); ends at the negedge of the release cycle.
    task automatic run_load(input logic [31:0] a, input bit with_wr, output int holds);
        bit done;
        done  = 1'b0;
        holds = 0;
        next_cycle();
        core_rd_en = 1'b1;
        core_wr_en = with_wr;
        core_addr  = a;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!core_hold) done = 1'b1;
            else begin
                holds++;
                next_cycle();
            end
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL load_timeout: observed hold stuck, expected release");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (dbg_state == ST_IDLE && wbuf_count == 3'd0 && !bus_req) done = 1'b1;
            else next_cycle();
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL idle_timeout: observed bridge busy, expected idle");
        end
    endtask

    initial begin
        int          holds;
        int          hv [5];
        logic [2:0]  fc;
        logic [2:0]  fcv [5];

        // ---- 1: reset and single store ----
        core_rd_en = 1'b1;
        @(negedge clk);
        check("rst_bus_req", 96'(bus_req), 96'(0));
        check("rst_bus_we", 96'(bus_we), 96'(0));
        check("rst_bus_addr", 96'(bus_addr), 96'(0));
        check("rst_bus_wdata", 96'(bus_wdata), 96'(0));
        check("rst_core_rdata", 96'(core_rdata), 96'(0));
        check("rst_wbuf_count", 96'(wbuf_count), 96'(0));
        check("rst_state", 96'(dbg_state), 96'(ST_IDLE));
        check("rst_hold_forced", 96'(core_hold), 96'(0));
        next_cycle();
        rst = 1'b0;
        core_rd_en = 1'b0;
        next_cycle();

        exp_q.push_back({1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
        store_hold(32'h0000_0100, 32'hDEAD_BEEF, holds, fc);
        check("t1_store_hold", 96'(holds), 96'(0));
        next_cycle();
        core_wr_en = 1'b0;
        @(negedge clk);
        check("t1_count_c1", 96'(wbuf_count), 96'(1));
        check("t1_req_c1", 96'(bus_req), 96'(0));
        check("t1_hold_c1", 96'(core_hold), 96'(0));
        next_cycle();
        @(negedge clk);
        check("t1_req_c2", 96'(bus_req), 96'(1));
        check("t1_we_c2", 96'(bus_we), 96'(1));
        check("t1_addr_c2", 96'(bus_addr), 96'(32'h0000_0100));
        check("t1_wdata_c2", 96'(bus_wdata), 96'(32'hDEAD_BEEF));
        check("t1_hold_c2", 96'(core_hold), 96'(0));
        next_cycle();
        @(negedge clk);
        check("t1_req_c3", 96'(bus_req), 96'(0));
        check("t1_count_c3", 96'(wbuf_count), 96'(0));

        // ---- 2: zero-wait load ----
        mem_model[32'h0000_0200] = 32'h1234_5678;
        exp_q.push_back({1'b0, 32'h0000_0200, 32'h1234_5678});
        run_load(32'h0000_0200, 1'b0, holds);
        check("t2_hold_cycles", 96'(holds), 96'(2));
        check("t2_rdata", 96'(core_rdata), 96'(32'h1234_5678));
        check("t2_state_rdone", 96'(dbg_state), 96'(ST_RDONE));
        next_cycle();
        core_rd_en = 1'b0;
        wait_idle();

        // ---- 3: fill and overflow, 3-wait slave ----
        wait_states = 3;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b1, 32'h0000_0400 + 32'(4 * i), 32'h1000_0000 + 32'(i)});
        end
        for (int i = 0; i < 5; i++) begin
            store_hold(32'h0000_0400 + 32'(4 * i), 32'h1000_0000 + 32'(i), hv[i], fcv[i]);
        end
        next_cycle();
        core_wr_en = 1'b0;
        check("t3_hold_st0", 96'(hv[0]), 96'(0));
        check("t3_hold_st3", 96'(hv[3]), 96'(0));
        check("t3_hold_st4", 96'(hv[4]), 96'(2));
        check("t3_count_full", 96'(fcv[4]), 96'(4));
        wait_idle();
        check("t3_drained", 96'(exp_q.size()), 96'(0));

        // ---- 4: RAW ordering ----
        wait_states = 1;
        exp_q.push_back({1'b1, 32'h0000_0300, 32'hA5A5_A5A5});
        exp_q.push_back({1'b0, 32'h0000_0300, 32'hA5A5_A5A5});
        store_hold(32'h0000_0300, 32'hA5A5_A5A5, holds, fc);
        run_load(32'h0000_0300, 1'b0, holds);
        check("t4_hold_cycles", 96'(holds), 96'(6));
        check("t4_rdata", 96'(core_rdata), 96'(32'hA5A5_A5A5));
        next_cycle();
        core_rd_en = 1'b0;
        wait_idle();

        // ---- 5: reset mid-read ----
        wait_states = 5;
        mem_model[32'h0000_0500] = 32'h55AA_1234;
        next_cycle();
        core_rd_en = 1'b1;
        core_addr  = 32'h0000_0500;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("t5_req_before", 96'(bus_req), 96'(1));
        check("t5_state_read", 96'(dbg_state), 96'(ST_READ));
        rst = 1'b1;
        #1;
        check("t5_req_async", 96'(bus_req), 96'(0));
        check("t5_rdata_clr", 96'(core_rdata), 96'(0));
        check("t5_count_clr", 96'(wbuf_count), 96'(0));
        check("t5_hold_forced", 96'(core_hold), 96'(0));
        check("t5_state_idle", 96'(dbg_state), 96'(ST_IDLE));
        next_cycle();
        rst = 1'b0;
        core_rd_en = 1'b0;
        next_cycle();
        wait_states = 0;
        mem_model[32'h0000_0600] = 32'h0BAD_F00D;
        exp_q.push_back({1'b0, 32'h0000_0600, 32'h0BAD_F00D});
        run_load(32'h0000_0600, 1'b0, holds);
        check("t5_fresh_holds", 96'(holds), 96'(2));
        check("t5_fresh_rdata", 96'(core_rdata), 96'(32'h0BAD_F00D));
        next_cycle();
        core_rd_en = 1'b0;
        wait_idle();

        // ---- 6: spurious ack, then illegal rd+wr ----
        next_cycle();
        spur_ack = 1'b1;
        next_cycle();
        spur_ack = 1'b0;
        @(negedge clk);
        check("t6_spur_state", 96'(dbg_state), 96'(ST_IDLE));
        check("t6_spur_req", 96'(bus_req), 96'(0));
        check("t6_spur_count", 96'(wbuf_count), 96'(0));
        check("t6_spur_rdata", 96'(core_rdata), 96'(32'h0BAD_F00D));

        mem_model[32'h0000_0700] = 32'h7777_7777;
        exp_q.push_back({1'b0, 32'h0000_0700, 32'h7777_7777});
        core_wdata = 32'hFFFF_0000;
        run_load(32'h0000_0700, 1'b1, holds);
        check("t6_ill_holds", 96'(holds), 96'(2));
        check("t6_ill_rdata", 96'(core_rdata), 96'(32'h7777_7777));
        check("t6_ill_count", 96'(wbuf_count), 96'(0));
        next_cycle();
        core_rd_en = 1'b0;
        core_wr_en = 1'b0;
        @(negedge clk);
        check("t6_no_push", 96'(wbuf_count), 96'(0));
        next_cycle();
        @(negedge clk);
        check("t6_no_write_req", 96'(bus_req), 96'(0));
        check("t6_illegal_flagged", 96'(illegal_cycles != 0), 96'(1));
        repeat (3) next_cycle();
        check("final_exp_q_empty", 96'(exp_q.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlx_data_mem_bridge.md
# dlx_data_mem_bridge

Data-side memory interface of the uDLX core: sits directly downstream of the processor's MEM-stage data port (`data_rd_en`, `data_wr_en`, `data_addr`, `data_write`, `data_read`). It converts the core's single-cycle access model into a variable-latency req/ack bus. Stores go into a posted write buffer, so writes never stall the core unless the buffer is full. Loads drain the buffer first, then stall the core through `core_hold` until the read data returns.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `DATA_ADDR_WIDTH`, 32, byte address width
- `WBUF_DEPTH`, 4, write-buffer entries; power of two, ≥2
- `clk  in  1  clock; all state on rising edge`
- `rst  in  1  reset; asynchronous, active-high`
- `core_rd_en  in  1  load request; held stable with core_addr while core_hold=1`
- `core_wr_en  in  1  store request`
- `core_addr  in  DATA_ADDR_WIDTH  access address`
- `core_wdata  in  DATA_WIDTH  store data`
- `core_rdata  out  DATA_WIDTH  load data, registered`
- `core_hold  out  1  stall request to core pipeline`
- `wbuf_count  out  $clog2(WBUF_DEPTH)+1  buffered writes pending`
- `bus_req  out  1  transaction request, registered`
- `bus_we  out  1  1 = write, 0 = read`
- `bus_addr  out  DATA_ADDR_WIDTH  transaction address`
- `bus_wdata  out  DATA_WIDTH  write data`
- `bus_ack  in  1  completion; sampled only while bus_req=1`
- `bus_rdata  in  DATA_WIDTH  read data, valid in the ack cycle`

## Operation
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, core_rdata=0, wbuf_count=0, FSM=IDLE, rd_done=0. core_hold is forced to 0 while rst=1.
- Write buffer: FIFO of {addr, data}.
  - Push when core_wr_en=1, core_rd_en=0, and not full. Full is computed from the registered count, so a push is refused when full even if a pop happens in the same cycle.
  - Pop on the ack edge of a bus write.
- core_hold is combinational:
  - `(core_rd_en & ~rd_done) | (core_wr_en & ~core_rd_en & full)`
- core_rd_en and core_wr_en both high is illegal. The read is served and the write is dropped; the bench flags it.
- FSM states and transitions:
  - IDLE → WRITE when wbuf_count>0. Load bus_we=1, addr/wdata from the FIFO head, and set bus_req.
  - IDLE → READ when wbuf_count==0, core_rd_en=1, and rd_done=0. Load bus_we=0, addr=core_addr, and set bus_req.
  - Writes have priority over reads. This guarantees RAW ordering; there is no forwarding.
  - WRITE: hold all bus outputs stable. On bus_ack, pop the FIFO, clear bus_req, and go to IDLE.
  - READ: hold outputs stable. On bus_ack, capture bus_rdata into core_rdata, clear bus_req, set rd_done, and go to RDONE.
  - RDONE: one cycle in which core_hold=0 and the core consumes the load. Clear rd_done and go to IDLE.
- core_rdata holds its value until the next read capture.
- No new stores are pushed while a read is held, because the core is stalled.

## Timing
- Bus protocol:
  - bus_req, bus_we, bus_addr and bus_wdata are stable from assertion through the ack cycle.
  - bus_req drops after ack, giving at least one idle cycle between transactions.
  - bus_ack while bus_req=0 is ignored.
- Load with the buffer empty and a zero-wait slave:
  - rd_en in cycle 0 → bus_req in cycle 1, ack in cycle 1.
  - core_hold=1 in cycles 0–1; core_hold=0 in cycle 2 with core_rdata valid.
  - Each slave wait state adds one cycle.
- Store: pushed at the end of the rd_en/wr_en cycle c → wbuf_count=1 in c+1 → bus_req in c+2. Zero core stall.
- Load behind N buffered writes: all N writes complete on the bus before the read bus_req is raised.
- Reset mid-transaction: asynchronously clears bus_req, the FSM and the FIFO. The pending transaction is abandoned, and the slave must tolerate the dropped req.

## Structure
- Package `dlx_mem_pkg` holds:
  - the FSM state enum (IDLE, WRITE, READ, RDONE);
  - the `BUS_RD`/`BUS_WR` constants for bus_we.
- Sub-module `dlx_wbuf_fifo`: synchronous FIFO with parameters WIDTH=DATA_ADDR_WIDTH+DATA_WIDTH and DEPTH=WBUF_DEPTH.
  - Ports: push, pop, head, full, empty, count.
  - Pointers wrap modulo DEPTH.
- The FSM, read capture and hold logic live in the top module.

## Test plan
1. **Reset and single store.** Reset, then a single store addr=0x100, data=0xDEADBEEF. Require core_hold=0 throughout, bus_req rising 2 cycles later with bus_we=1 and the same addr/data, and wbuf_count returning to 0 after ack.
2. **Zero-wait load.** Load 0x200 with a zero-wait slave returning 0x12345678. Require exactly 2 hold cycles, then core_rdata=0x12345678 with core_hold=0.
3. **Fill and overflow.** Issue 5 back-to-back stores with WBUF_DEPTH=4 and a 3-wait slave. Require hold on the 5th store while full, and all 5 writes appearing on the bus in program order.
4. **RAW ordering.** Store 0x300←0xA5A5A5A5, then immediately load 0x300 from a memory model. Require the bus write to precede the bus read, and core_rdata=0xA5A5A5A5.
5. **Reset mid-read.** Assert rst during a READ wait state. Require bus_req=0 asynchronously, core_rdata=0 and wbuf_count=0; after release, a fresh load completes normally.
6. **Spurious ack and illegal request.** Pulse bus_ack while idle: no state change. Assert rd_en and wr_en together: the read is served, no FIFO push occurs, and the checker flags an error.
